motor_axil_cmd_arbiter: RTL and testbench

Two-port command arbiter and AXI4-Lite master sequencer for the motor IP register file. It accepts single-register read/write commands from two on-chip requesters (port 0: puck-tracking controller, port 1: host/debug path) and grants them round-robin. It serialises the granted command onto one AXI4-Lite master interface and returns the slave's data and response to the granted requester. It sits between the image-processing control logic and the motor IP's S00_AXI slave.

---
 rtl/motor_axil_cmd_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_motor_axil_cmd_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_axil_cmd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | motor_axil_cmd_arbiter                                                   |
// | Round-robin two-port register command arbiter driving one AXI4-Lite      |
// | master towards the motor IP register file.                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module motor_axil_cmd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic                      req0_write,
  input  logic [ADDR_WIDTH-1:0]     req0_addr,
  input  logic [DATA_WIDTH-1:0]     req0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req0_wstrb,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic                      req1_write,
  input  logic [ADDR_WIDTH-1:0]     req1_addr,
  input  logic [DATA_WIDTH-1:0]     req1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req1_wstrb,
  output logic                      rsp0_valid,
  output logic [DATA_WIDTH-1:0]     rsp0_rdata,
  output logic [1:0]                rsp0_resp,
  output logic                      rsp1_valid,
  output logic [DATA_WIDTH-1:0]     rsp1_rdata,
  output logic [1:0]                rsp1_resp,
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY,
  output logic                      busy,
  output logic                      grant_id,
  output logic [7:0]                err_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                  state_q;
  logic                    last_grant_q, grant_id_q, busy_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                    rsp0_valid_q, rsp1_valid_q;
  logic [DATA_WIDTH-1:0]   rsp0_rdata_q, rsp1_rdata_q;
  logic [1:0]              rsp0_resp_q, rsp1_resp_q;
  logic [7:0]              err_q;

  logic                    w_idle, w_sel, w_accept;
  logic                    w_cmd_write;
  logic [ADDR_WIDTH-1:0]   w_cmd_addr;
  logic [DATA_WIDTH-1:0]   w_cmd_wdata;
  logic [STRB_WIDTH-1:0]   w_cmd_wstrb;
  logic                    w_aw_fin, w_w_fin, w_cap_fire;
  logic [DATA_WIDTH-1:0]   w_cap_rdata;
  logic [1:0]              w_cap_resp, w_done_resp;

  // With both requesting, the port that did not win last time goes next.
  assign w_idle      = (state_q == S_IDLE);
  assign w_sel       = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign w_accept    = w_idle & (req0_valid | req1_valid);
  assign req0_ready  = w_idle & req0_valid & ~w_sel;
  assign req1_ready  = w_idle & req1_valid & w_sel;

  assign w_cmd_write = w_sel ? req1_write : req0_write;
  assign w_cmd_addr  = w_sel ? req1_addr  : req0_addr;
  assign w_cmd_wdata = w_sel ? req1_wdata : req0_wdata;
  assign w_cmd_wstrb = w_sel ? req1_wstrb : req0_wstrb;

  assign w_aw_fin    = ~awvalid_q | M_AXI_AWREADY;
  assign w_w_fin     = ~wvalid_q  | M_AXI_WREADY;
  assign w_done_resp = grant_id_q ? rsp1_resp_q : rsp0_resp_q;

  always_comb begin
    w_cap_fire  = 1'b0;
    w_cap_rdata = '0;
    w_cap_resp  = 2'b00;
    if (state_q == S_WRESP && M_AXI_BVALID) begin
      w_cap_fire = 1'b1;
      w_cap_resp = M_AXI_BRESP;
    end else if (state_q == S_RDATA && M_AXI_RVALID) begin
      w_cap_fire  = 1'b1;
      w_cap_rdata = M_AXI_RDATA;
      w_cap_resp  = M_AXI_RRESP;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      rsp0_resp_q  <= 2'b00;
      rsp1_resp_q  <= 2'b00;
      err_q        <= 8'd0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;

      // Per-port response registers change only when that port completes.
      if (w_cap_fire) begin
        if (grant_id_q) begin
          rsp1_rdata_q <= w_cap_rdata;
          rsp1_resp_q  <= w_cap_resp;
          rsp1_valid_q <= 1'b1;
        end else begin
          rsp0_rdata_q <= w_cap_rdata;
          rsp0_resp_q  <= w_cap_resp;
          rsp0_valid_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            grant_id_q   <= w_sel;
            last_grant_q <= w_sel;
            busy_q       <= 1'b1;
            addr_q       <= w_cmd_addr;
            wdata_q      <= w_cmd_wdata;
            wstrb_q      <= w_cmd_wstrb;
            if (w_cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RADDR;
            end
          end
        end
        S_WADDR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if (w_aw_fin && w_w_fin) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            rready_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_done_resp != 2'b00 && err_q != 8'hFF) err_q <= err_q + 8'd1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp0_valid    = rsp0_valid_q;
  assign rsp0_rdata    = rsp0_rdata_q;
  assign rsp0_resp     = rsp0_resp_q;
  assign rsp1_valid    = rsp1_valid_q;
  assign rsp1_rdata    = rsp1_rdata_q;
  assign rsp1_resp     = rsp1_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign busy          = busy_q;
  assign grant_id      = grant_id_q;
  assign err_count     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_axil_cmd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_motor_axil_cmd_arbiter                                                |
// | Random and directed traffic against a transaction-level arbiter model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_motor_axil_cmd_arbiter;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } cmd_t;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic [3:0]  req0_wstrb = 0, req1_wstrb = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [1:0]  rsp0_resp, rsp1_resp;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY = 0, WREADY = 0, BVALID = 0, ARREADY = 0, RVALID = 0;
  logic [1:0]  BRESP = 0, RRESP = 0;
  logic [31:0] RDATA = 0;
  logic        busy, grant_id;
  logic [7:0]  err_count;

  motor_axil_cmd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_resp(rsp0_resp),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_resp(rsp1_resp),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
    .M_AXI_AWREADY(AWREADY), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY), .busy(busy), .grant_id(grant_id), .err_count(err_count)
  );

  int n_cmp = 0, n_fail = 0, cyc = 0;

  // Requester queues
  cmd_t q0[$], q1[$];
  bit   acc_flag = 0, acc_port = 0;

  // Transaction-level model
  bit          m_busy = 0, m_port = 0, m_last = 1, m_gid = 0;
  cmd_t        m_cmd;
  bit          m_aw_done, m_w_done, m_ar_done, m_rsp_now;
  logic [1:0]  m_rsp_resp;
  int          m_err = 0;
  logic [31:0] m_mem [logic [31:0]];
  logic [31:0] m_hold_d [2];
  logic [1:0]  m_hold_r [2];
  int          acc_log[$], grant_log[$];
  int          last_rsp_cyc = 0;

  // AXI slave
  logic [31:0] s_mem [logic [31:0]];
  bit          s_aw = 0, s_w = 0, s_b_pend = 0, s_r_pend = 0;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          cfg_rand = 0;
  int          cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0, cfg_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int pw(input int fixed);
    return cfg_rand ? int'($urandom_range(0, 3)) : fixed;
  endfunction

  function automatic logic [1:0] pick_resp();
    if (cfg_err == 0) return 2'b00;
    if (cfg_err == 1) return 2'b10;
    return ($urandom_range(0, 5) == 0) ? 2'(1 + $urandom_range(1, 2)) : 2'b00;
  endfunction

  task automatic slave_load();
    aw_cnt = pw(cfg_aw); w_cnt = pw(cfg_w); b_cnt = pw(cfg_b);
    ar_cnt = pw(cfg_ar); r_cnt = pw(cfg_r);
  endtask

  task automatic push(input bit p, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    cmd_t c;
    c.write = w; c.addr = a; c.data = d; c.strb = s;
    if (p) q1.push_back(c); else q0.push_back(c);
  endtask

  task automatic model_check();
    bit e0, e1, eaw, ew, eb, ear, er;
    if (ARESET) return;
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("err_count", err_count, m_err);
    e0 = !m_busy && req0_valid && (!req1_valid || m_last);
    e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    eaw = m_busy && m_cmd.write && !m_aw_done;
    ew  = m_busy && m_cmd.write && !m_w_done;
    eb  = m_busy && m_cmd.write && m_aw_done && m_w_done && !m_rsp_now;
    ear = m_busy && !m_cmd.write && !m_ar_done;
    er  = m_busy && !m_cmd.write && m_ar_done && !m_rsp_now;
    chk("awvalid", AWVALID, eaw);
    chk("wvalid", WVALID, ew);
    chk("bready", BREADY, eb);
    chk("arvalid", ARVALID, ear);
    chk("rready", RREADY, er);
    chk("prot", {AWPROT, ARPROT}, 0);
    if (eaw) chk("awaddr", AWADDR, m_cmd.addr);
    if (ew)  chk("wdata", {WDATA[27:0], WSTRB}, {m_cmd.data[27:0], m_cmd.strb});
    if (ear) chk("araddr", ARADDR, m_cmd.addr);
    chk("rsp0_valid", rsp0_valid, m_busy && m_rsp_now && !m_port);
    chk("rsp1_valid", rsp1_valid, m_busy && m_rsp_now && m_port);
    chk("rsp0_rdata", rsp0_rdata, m_hold_d[0]);
    chk("rsp1_rdata", rsp1_rdata, m_hold_d[1]);
    chk("rsp_resp", {rsp1_resp, rsp0_resp}, {m_hold_r[1], m_hold_r[0]});

    // Advance the model across the coming clock edge.
    if (!m_busy) begin
      if (e0 || e1) begin
        m_busy = 1; m_port = e1; m_last = e1; m_gid = e1;
        m_cmd.write = e1 ? req1_write : req0_write;
        m_cmd.addr  = e1 ? req1_addr  : req0_addr;
        m_cmd.data  = e1 ? req1_wdata : req0_wdata;
        m_cmd.strb  = e1 ? req1_wstrb : req0_wstrb;
        m_aw_done = 0; m_w_done = 0; m_ar_done = 0; m_rsp_now = 0;
        acc_log.push_back(cyc); grant_log.push_back(int'(e1));
        acc_flag = 1; acc_port = e1;
      end
    end else if (m_rsp_now) begin
      if (m_rsp_resp != 2'b00 && m_err < 255) m_err++;
      m_busy = 0; last_rsp_cyc = cyc;
    end else if (m_cmd.write) begin
      if (eb && BVALID) begin
        m_hold_d[m_port] = 0; m_hold_r[m_port] = BRESP; m_rsp_resp = BRESP;
        m_mem[m_cmd.addr] = merge(m_mem.exists(m_cmd.addr) ? m_mem[m_cmd.addr] : 0,
                                  m_cmd.data, m_cmd.strb);
        m_rsp_now = 1;
      end
      if (eaw && AWREADY) m_aw_done = 1;
      if (ew && WREADY) m_w_done = 1;
    end else begin
      if (er && RVALID) begin
        m_hold_d[m_port] = m_mem.exists(m_cmd.addr) ? m_mem[m_cmd.addr] : 0;
        m_hold_r[m_port] = RRESP; m_rsp_resp = RRESP; m_rsp_now = 1;
      end
      if (ear && ARREADY) m_ar_done = 1;
    end
  endtask

  task automatic slave_sample();
    if (ARESET) return;
    if (AWVALID && AWREADY) begin s_aw = 1; s_awaddr = AWADDR; aw_cnt = pw(cfg_aw); end
    if (WVALID && WREADY) begin s_w = 1; s_wdata = WDATA; s_wstrb = WSTRB; w_cnt = pw(cfg_w); end
    if (s_aw && s_w) begin
      s_mem[s_awaddr] = merge(s_mem.exists(s_awaddr) ? s_mem[s_awaddr] : 0, s_wdata, s_wstrb);
      s_aw = 0; s_w = 0; s_b_pend = 1; b_cnt = pw(cfg_b);
    end
    if (BVALID && BREADY) s_b_pend = 0;
    if (ARVALID && ARREADY) begin
      s_r_pend = 1; s_araddr = ARADDR; ar_cnt = pw(cfg_ar); r_cnt = pw(cfg_r);
    end
    if (RVALID && RREADY) s_r_pend = 0;
  endtask

  task automatic drive();
    cmd_t c;
    if (acc_flag) begin
      if (acc_port) req1_valid = 0; else req0_valid = 0;
      acc_flag = 0;
    end
    if (!req0_valid && q0.size() > 0) begin
      c = q0.pop_front();
      req0_valid = 1; req0_write = c.write; req0_addr = c.addr; req0_wdata = c.data; req0_wstrb = c.strb;
    end
    if (!req1_valid && q1.size() > 0) begin
      c = q1.pop_front();
      req1_valid = 1; req1_write = c.write; req1_addr = c.addr; req1_wdata = c.data; req1_wstrb = c.strb;
    end
    AWREADY = 0; WREADY = 0; ARREADY = 0;
    if (AWVALID) begin if (aw_cnt > 0) aw_cnt--; else AWREADY = 1; end
    if (WVALID)  begin if (w_cnt > 0)  w_cnt--;  else WREADY = 1;  end
    if (ARVALID) begin if (ar_cnt > 0) ar_cnt--; else ARREADY = 1; end
    if (!s_b_pend) begin BVALID = 0; BRESP = 0; end
    else if (!BVALID) begin
      if (b_cnt > 0) b_cnt--; else begin BVALID = 1; BRESP = pick_resp(); end
    end
    if (!s_r_pend) begin RVALID = 0; RRESP = 0; RDATA = $urandom; end
    else if (!RVALID) begin
      if (r_cnt > 0) r_cnt--;
      else begin
        RVALID = 1; RRESP = pick_resp();
        RDATA = s_mem.exists(s_araddr) ? s_mem[s_araddr] : 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    cyc++;
    model_check();
    slave_sample();
    @(posedge ACLK);
    #1;
    drive();
  endtask

  task automatic do_reset();
    #2 ARESET = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_axi_valid", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp_data", rsp0_rdata | rsp1_rdata | {28'd0, rsp0_resp, rsp1_resp}, 0);
    chk("rst_addr", AWADDR | ARADDR | WDATA, 0);
    chk("rst_gid_err", {grant_id, err_count}, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    m_busy = 0; m_last = 1; m_gid = 0; m_err = 0; m_rsp_now = 0;
    m_hold_d[0] = 0; m_hold_d[1] = 0; m_hold_r[0] = 0; m_hold_r[1] = 0;
    acc_flag = 0; q0.delete(); q1.delete();
    req0_valid = 0; req1_valid = 0;
    s_aw = 0; s_w = 0; s_b_pend = 0; s_r_pend = 0;
    BVALID = 0; RVALID = 0; AWREADY = 0; WREADY = 0; ARREADY = 0;
    slave_load();
    repeat (2) tick();
    ARESET = 0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((m_busy || q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", bound);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int exp_g[8];
    int n;
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1};
    slave_load();
    do_reset();

    // Single write then read-back from port 0, zero-wait slave
    push(0, 1, 32'h0, 32'h0101FFFF, 4'hF);
    drain(50);
    chk("t1_wr_latency", last_rsp_cyc - acc_log[$], 3);
    push(0, 0, 32'h0, 32'h0, 4'h0);
    drain(50);
    chk("t1_rd_latency", last_rsp_cyc - acc_log[$], 3);
    chk("t1_rdata", rsp0_rdata, 32'h0101FFFF);
    chk("t1_resp", rsp0_resp, 2'b00);

    // Simultaneous requests after reset alternate grants
    do_reset();
    acc_log.delete(); grant_log.delete();
    push(0, 1, 32'h4, 32'habcd0001, 4'hF);
    push(1, 1, 32'h8, 32'hdead0011, 4'hF);
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 32'h4, 0, 0);
      push(1, 0, 32'h8, 0, 0);
    end
    drain(100);
    chk("t2_grants", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("t2_grant_seq", grant_log[i], exp_g[i]);
    if (acc_log.size() >= 3) begin
      chk("t2_throughput_a", acc_log[1] - acc_log[0], 4);
      chk("t2_throughput_b", acc_log[2] - acc_log[1], 4);
    end
    chk("t2_rdata0", rsp0_rdata, 32'habcd0001);
    chk("t2_rdata1", rsp1_rdata, 32'hdead0011);

    // W accepted three cycles ahead of AW
    cfg_aw = 3; cfg_w = 0; slave_load();
    push(0, 1, 32'h10, 32'h12345678, 4'b0110);
    drain(50);
    chk("t3_latency", last_rsp_cyc - acc_log[$], 6);
    cfg_aw = 0; slave_load();
    push(0, 0, 32'h10, 0, 0);
    drain(50);
    chk("t3_rdata", rsp0_rdata, 32'h00345600);

    // Error responses and counter saturation
    push(0, 1, 32'hC, 32'hbeef0011, 4'hF);
    drain(50);
    cfg_err = 1;
    push(1, 0, 32'hC, 0, 0);
    drain(50);
    chk("t4_resp", rsp1_resp, 2'b10);
    chk("t4_rdata", rsp1_rdata, 32'hbeef0011);
    chk("t4_err1", err_count, 1);
    for (int i = 0; i < 300; i++) push(bit'(i % 2), 0, 32'hC, 0, 0);
    drain(3000);
    chk("t4_err_sat", err_count, 255);
    cfg_err = 0;

    // Reset while waiting for read data
    do_reset();
    cfg_r = 10; slave_load();
    push(1, 0, 32'hC, 0, 0);
    n = 0;
    while (!(m_busy && m_ar_done) && n < 20) begin tick(); n++; end
    tick();
    chk("t5_in_rdata", {busy, RREADY}, 2'b11);
    do_reset();
    repeat (12) tick();
    cfg_r = 0; slave_load();
    push(1, 0, 32'hC, 0, 0);
    drain(50);
    chk("t5_reissue", rsp1_rdata, 32'hbeef0011);

    // Random traffic with random slave waits and responses
    cfg_rand = 1; cfg_err = 2; slave_load();
    for (int i = 0; i < 200; i++)
      push(bit'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(1, 15)));
    drain(6000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
